// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux event counter slice.
package demux_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned POP_W  = 4;

  function automatic logic [POP_W-1:0] popcount8(input logic [NUM_CH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic is_multi_hot(input logic [NUM_CH-1:0] v);
    return popcount8(v) > POP_W'(1);
  endfunction

endpackage

// File: rtl/demux_event_counter_if.sv
// Bus between the demux/host side and the event counter.
interface demux_event_counter_if #(
  parameter int unsigned CNT_W = 8
);
  import demux_pkg::*;

  logic [NUM_CH-1:0] f;
  logic              clr;
  logic              rd_req;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic              err_multi;

  modport master (
    output f, clr, rd_req, rd_sel,
    input  rd_valid, rd_data, err_multi
  );

  modport slave (
    input  f, clr, rd_req, rd_sel,
    output rd_valid, rd_data, err_multi
  );

endinterface

// File: rtl/demux_event_counter_sat_counter.sv
// Saturating event counter with a local clear and a higher-priority global clear.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr_any,
  input  logic             clr_all,
  output logic [CNT_W-1:0] q
);

  // A local clear coinciding with an event restarts at 1 so the event is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr_all) begin
      q <= '0;
    end else if (clr_any) begin
      q <= inc ? CNT_W'(1) : '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux_event_counter.sv
// Per-channel rising-edge counter for the 1-to-8 demux output, with a registered read port.
module demux_event_counter
  import demux_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter bit          CLR_ON_READ = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  demux_event_counter_if.slave  bus
);

  logic [NUM_CH-1:0] f_q;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] rd_clr;
  logic [CNT_W-1:0]  cnt [NUM_CH];

  assign rise = bus.f & ~f_q;

  for (genvar gi = 0; gi < int'(NUM_CH); gi++) begin : g_ch
    assign rd_clr[gi] = CLR_ON_READ && bus.rd_req && (bus.rd_sel == SEL_W'(gi));

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (rise[gi]),
      .clr_any (bus.clr | rd_clr[gi]),
      .clr_all (bus.clr),
      .q       (cnt[gi])
    );
  end

  // Read returns the pre-update count; rd_data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q           <= '0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
      bus.err_multi <= 1'b0;
    end else begin
      f_q          <= bus.f;
      bus.rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        bus.rd_data <= cnt[bus.rd_sel];
      end
      if (bus.clr) begin
        bus.err_multi <= 1'b0;
      end else if (is_multi_hot(bus.f)) begin
        bus.err_multi <= 1'b1;
      end
    end
  end

endmodule
